// File: rtl/debounce_timer_arbiter.sv
// Four button channels share one delay timer: grant on arbitration, done pulse DELAY_CYCLES later, no backpressure.
// Selection is fixed priority (ch0 highest) unless DEBOUNCE_ARB_ROUNDROBIN_EN is defined.
module debounce_timer_arbiter #(
  parameter int unsigned DELAY_CYCLES = 50000
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [3:0] done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] LOAD = 16'(DELAY_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] count;
  logic [15:0] count_nxt;
  logic [3:0]  grant_nxt;
  logic [3:0]  done_nxt;
  logic        found;
  logic [1:0]  pick_idx;
  logic [3:0]  pick;

`ifdef DEBOUNCE_ARB_ROUNDROBIN_EN
  logic [1:0] ptr;
  logic [1:0] cand;

  // Scan from the highest offset down so the channel nearest the pointer wins.
  always_comb begin
    found    = 1'b0;
    pick_idx = 2'd0;
    cand     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Advances on every grant, aborted services included.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (state == IDLE && found) begin
      ptr <= pick_idx + 2'd1;
    end
  end
`else
  always_comb begin
    found    = 1'b0;
    pick_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        found    = 1'b1;
        pick_idx = 2'(i);
      end
    end
  end
`endif

  assign pick = found ? (4'b0001 << pick_idx) : 4'b0000;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    grant_nxt = grant;
    done_nxt  = 4'b0000;
    case (state)
      IDLE: begin
        grant_nxt = 4'b0000;
        if (found) begin
          state_nxt = COUNT;
          grant_nxt = pick;
          count_nxt = LOAD;
        end
      end
      COUNT: begin
        // Losing the owner's request takes precedence over expiry.
        if ((req & grant) == 4'b0000) begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
        end else if (count == 16'd0) begin
          state_nxt = DONE;
          done_nxt  = grant;
        end else begin
          count_nxt = count - 16'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 16'd0;
      grant <= 4'b0000;
      done  <= 4'b0000;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      grant <= grant_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Scoreboarded bench for debounce_timer_arbiter: DELAY_CYCLES=4 instance plus a DELAY_CYCLES=1 boundary instance.
module tb_debounce_timer_arbiter;

  logic       clk5 = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] done;
  logic       busy;
  logic [3:0] req1;
  logic [3:0] grant1;
  logic [3:0] done1;
  logic       busy1;

  always #5 clk5 = ~clk5;

  debounce_timer_arbiter #(.DELAY_CYCLES(4)) dut (
    .clk5  (clk5),
    .reset (reset),
    .req   (req),
    .grant (grant),
    .done  (done),
    .busy  (busy)
  );

  debounce_timer_arbiter #(.DELAY_CYCLES(1)) dut1 (
    .clk5  (clk5),
    .reset (reset),
    .req   (req1),
    .grant (grant1),
    .done  (done1),
    .busy  (busy1)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected grant / done values queued by stimulus, consumed by the monitor.
  logic [3:0] exp_g[$];
  logic [3:0] exp_d[$];
  int         cyc        = 0;
  int         rise_cyc   = 0;
  logic [3:0] prev_grant = 4'b0000;
  logic [3:0] prev_done  = 4'b0000;

  always @(negedge clk5) begin
    cyc++;
    if (grant != 4'b0000 && prev_grant == 4'b0000) begin
      rise_cyc = cyc;
      if (exp_g.size() == 0) chk("sb_grant_unexpected", 32'(grant), 0);
      else                   chk("sb_grant", 32'(grant), 32'(exp_g.pop_front()));
    end
    if (done != 4'b0000) begin
      if (exp_d.size() == 0) chk("sb_done_unexpected", 32'(done), 0);
      else                   chk("sb_done", 32'(done), 32'(exp_d.pop_front()));
      chk("sb_done_latency", cyc - rise_cyc, 4);
      chk("sb_grant_during_done", 32'(grant), 32'(done));
    end
    if (prev_done != 4'b0000) chk("sb_grant_clear_after_done", 32'(grant), 0);
    prev_grant = grant;
    prev_done  = done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk5);
    #2;
  endtask

  task automatic wait_done(input int budget, output logic [3:0] d);
    d = 4'b0000;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk5);
      #2;
      if (done != 4'b0000 && d == 4'b0000) d = done;
      if (d != 4'b0000) break;
    end
    if (d == 4'b0000) chk("wait_done_timeout", 1, 0);
  endtask

  logic [3:0] d;
  logic [3:0] pat [3];
  int         busy_cnt;

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    req1  = 4'b0000;
    tick(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant1", 32'(grant1), 0);
    reset = 1'b0;
    tick(2);
    chk("idle_no_req_grant", 32'(grant), 0);
    chk("idle_no_req_busy", 32'(busy), 0);

    // Single request on channel 0.
    req = 4'b0001;
    exp_g.push_back(4'b0001);
    exp_d.push_back(4'b0001);
    busy_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      busy_cnt += int'(busy);
      if (k == 1) chk("s1_grant", 32'(grant), 1);
      if (k == 4) chk("s1_no_early_done", 32'(done), 0);
      if (k == 5) chk("s1_done", 32'(done), 1);
      if (k == 6) chk("s1_grant_clear", 32'(grant), 0);
    end
    chk("s1_busy_cycles", busy_cnt, 5);
    req = 4'b0000;
    tick(2);

    // All four channels, each dropped after its own done.
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_g.push_back(4'(4'b0001 << i));
      exp_d.push_back(4'(4'b0001 << i));
    end
    for (int i = 0; i < 4; i++) begin
      wait_done(20, d);
      req = req & ~d;
      tick(1);
      chk("all_idle_gap_grant", 32'(grant), 0);
      chk("all_idle_gap_busy", 32'(busy), 0);
    end
    tick(2);

    // Channels 1 and 3 held together.
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
`ifdef DEBOUNCE_ARB_ROUNDROBIN_EN
    pat[0] = 4'b0010; pat[1] = 4'b1000; pat[2] = 4'b0010;
`else
    pat[0] = 4'b0010; pat[1] = 4'b0010; pat[2] = 4'b0010;
`endif
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      exp_g.push_back(pat[i]);
      exp_d.push_back(pat[i]);
    end
    for (int i = 0; i < 3; i++) begin
      wait_done(20, d);
      if (i == 2) req = 4'b0000;
      tick(1);
      chk("pair_idle_gap_grant", 32'(grant), 0);
    end
    tick(2);

    // Abort: owner drops its request mid-count.
    req = 4'b0100;
    exp_g.push_back(4'b0100);
    tick(1);
    chk("abort_grant", 32'(grant), 4);
    tick(1);
    req = 4'b0000;
    tick(1);
    chk("abort_grant_clear", 32'(grant), 0);
    chk("abort_busy", 32'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("abort_no_done", 32'(done), 0);
    end

    // Reset in the middle of COUNT.
    req = 4'b0010;
    exp_g.push_back(4'b0010);
    tick(1);
    chk("rstmid_pre_grant", 32'(grant), 2);
    tick(1);
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    chk("rstmid_grant", 32'(grant), 0);
    chk("rstmid_done", 32'(done), 0);
    chk("rstmid_busy", 32'(busy), 0);
    tick(1);
    reset = 1'b0;
    req = 4'b1001;
    exp_g.push_back(4'b0001);
    exp_d.push_back(4'b0001);
    tick(1);
    chk("rstmid_first_grant", 32'(grant), 1);
    wait_done(20, d);
    req = 4'b0000;
    tick(2);

    // DELAY_CYCLES = 1 boundary.
    req1 = 4'b0010;
    tick(1);
    chk("d1_grant", 32'(grant1), 2);
    chk("d1_no_done_yet", 32'(done1), 0);
    chk("d1_busy", 32'(busy1), 1);
    tick(1);
    chk("d1_done", 32'(done1), 2);
    chk("d1_grant_in_done", 32'(grant1), 2);
    req1 = 4'b0000;
    tick(1);
    chk("d1_grant_clear", 32'(grant1), 0);
    chk("d1_done_clear", 32'(done1), 0);
    chk("d1_idle", 32'(busy1), 0);

    tick(2);
    chk("sb_grants_outstanding", exp_g.size(), 0);
    chk("sb_dones_outstanding", exp_d.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
